// File: rtl/lock_key_seq_pkg.sv
// Shared types and sizing helpers for the lock key sequencer.
//   state_e    : controller states
//   KEY_BEATS  : default number of key bytes per load
//   beat_w()   : beat counter width for a given key width
//   fail_w()   : malformed-load counter width for a given tolerance
package lock_key_seq_pkg;

  localparam int unsigned KEY_W_DEF      = 32;
  localparam int unsigned NLANES_DEF     = 4;
  localparam int unsigned STROBE_CYC_DEF = 2;
  localparam int unsigned MAX_FAIL_DEF   = 3;

  localparam int unsigned KEY_BEATS = KEY_W_DEF / 8;
  localparam int unsigned BEAT_W    = $clog2(KEY_BEATS + 1);

  typedef enum logic [2:0] {
    S_NO_KEY,
    S_LOAD,
    S_READY,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP,
    S_LOCKOUT
  } state_e;

  function automatic int unsigned beat_w(input int unsigned key_w);
    return $clog2(key_w / 8 + 1);
  endfunction

  function automatic int unsigned fail_w(input int unsigned max_fail);
    return $clog2(max_fail + 1);
  endfunction

endpackage

// File: rtl/lock_key_shift.sv
// Key byte shifter: accumulates MSB-first key bytes and flags a correct
// (commit) or malformed (error) end of load.
//   i_beat          : accepted key byte this cycle
//   i_clear         : drop partial load
//   i_data, i_last  : key byte and end-of-key marker
//   o_shadow        : partially assembled key
//   o_commit_pulse_c: key_last on the final beat
//   o_error_pulse_c : key_last early, or final beat without key_last
module lock_key_shift
  import lock_key_seq_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_beat,
  input  logic             i_clear,
  input  logic [7:0]       i_data,
  input  logic             i_last,
  output logic [KEY_W-1:0] o_shadow,
  output logic             o_commit_pulse_c,
  output logic             o_error_pulse_c
);

  localparam int unsigned BEATS = KEY_W / 8;
  localparam int unsigned BW    = beat_w(KEY_W);

  logic [KEY_W-1:0] r_shadow;
  logic [BW-1:0]    r_beat;
  logic             w_final;

  // r_beat counts bytes already taken, so the final byte arrives at BEATS-1
  assign w_final          = (r_beat == BW'(BEATS - 1));
  assign o_commit_pulse_c = i_beat && i_last && w_final;
  assign o_error_pulse_c  = i_beat && (i_last != w_final);
  assign o_shadow         = r_shadow;

  // Any end of load (good, bad or aborted) restarts the assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_beat   <= '0;
    end else if (i_clear || o_commit_pulse_c || o_error_pulse_c) begin
      r_shadow <= '0;
      r_beat   <= '0;
    end else if (i_beat) begin
      r_shadow <= (r_shadow << 8) | KEY_W'(i_data);
      r_beat   <= r_beat + BW'(1);
    end
  end

endmodule

// File: rtl/lock_key_sequencer.sv
// Controller for the NAND-latch locked core: loads and commits the key,
// runs each request through setup/strobe/hold on core_en, returns the
// captured core outputs, and locks out after MAX_FAIL malformed loads.
//   key_*   : key byte stream in (valid/ready), key_clear drops the key
//   req_*   : request data in (valid/ready)
//   resp_*  : captured core outputs out (valid/ready)
//   core_*  : locked core drive (d, en, key) and its outputs (q)
//   key_loaded, lockout, fail_cnt : status
module lock_key_sequencer
  import lock_key_seq_pkg::*;
#(
  parameter int unsigned KEY_W      = KEY_W_DEF,
  parameter int unsigned NLANES     = NLANES_DEF,
  parameter int unsigned STROBE_CYC = STROBE_CYC_DEF,
  parameter int unsigned MAX_FAIL   = MAX_FAIL_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_valid,
  output logic                        key_ready,
  input  logic [7:0]                  key_data,
  input  logic                        key_last,
  input  logic                        key_clear,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [NLANES-1:0]           req_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [NLANES-1:0]           resp_data,
  output logic [NLANES-1:0]           core_d,
  output logic                        core_en,
  output logic [KEY_W-1:0]            core_key,
  input  logic [NLANES-1:0]           core_q,
  output logic                        key_loaded,
  output logic                        lockout,
  output logic [fail_w(MAX_FAIL)-1:0] fail_cnt
);

  localparam int unsigned FW = fail_w(MAX_FAIL);
  localparam int unsigned SW = $clog2(STROBE_CYC + 1);

  state_e            r_state, w_state_nxt;
  logic              r_core_en, w_core_en_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic [NLANES-1:0] r_core_d, w_core_d_nxt;
  logic [NLANES-1:0] r_resp_data, w_resp_data_nxt;
  logic [KEY_W-1:0]  r_core_key, w_core_key_nxt;
  logic              r_key_loaded, w_key_loaded_nxt;
  logic              r_lockout, w_lockout_nxt;
  logic [FW-1:0]     r_fail_cnt, w_fail_nxt;
  logic [SW-1:0]     r_strobe_cnt, w_strobe_nxt;

  logic              w_beat, w_clr_load, w_commit, w_error;
  logic [KEY_W-1:0]  w_shadow, w_key_full;

  // Ready flags decode the state register directly so handshakes line up
  assign key_ready  = (r_state == S_NO_KEY) || (r_state == S_LOAD);
  assign req_ready  = (r_state == S_READY);
  // key_clear wins over a same-cycle key byte
  assign w_clr_load = key_ready && key_clear;
  assign w_beat     = key_ready && key_valid && !key_clear;
  assign w_key_full = (w_shadow << 8) | KEY_W'(key_data);

  lock_key_shift #(.KEY_W(KEY_W)) u_shift (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_beat          (w_beat),
    .i_clear         (w_clr_load),
    .i_data          (key_data),
    .i_last          (key_last),
    .o_shadow        (w_shadow),
    .o_commit_pulse_c(w_commit),
    .o_error_pulse_c (w_error)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_NO_KEY;
      r_core_en    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_core_d     <= '0;
      r_resp_data  <= '0;
      r_core_key   <= '0;
      r_key_loaded <= 1'b0;
      r_lockout    <= 1'b0;
      r_fail_cnt   <= '0;
      r_strobe_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_en    <= w_core_en_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_core_d     <= w_core_d_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_core_key   <= w_core_key_nxt;
      r_key_loaded <= w_key_loaded_nxt;
      r_lockout    <= w_lockout_nxt;
      r_fail_cnt   <= w_fail_nxt;
      r_strobe_cnt <= w_strobe_nxt;
    end
  end

  // Next state and next output values; core_en and resp_valid trail the
  // state by one cycle, which gives SETUP a full cycle of low enable
  always_comb begin
    w_state_nxt      = r_state;
    w_core_en_nxt    = (r_state == S_STROBE);
    w_resp_valid_nxt = (r_state == S_RESP) && !(r_resp_valid && resp_ready);
    w_core_d_nxt     = r_core_d;
    w_resp_data_nxt  = r_resp_data;
    w_core_key_nxt   = r_core_key;
    w_key_loaded_nxt = r_key_loaded;
    w_lockout_nxt    = r_lockout;
    w_fail_nxt       = r_fail_cnt;
    w_strobe_nxt     = r_strobe_cnt;

    case (r_state)
      S_NO_KEY, S_LOAD: begin
        if (w_clr_load) begin
          w_state_nxt = S_NO_KEY;
        end else if (w_commit) begin
          w_core_key_nxt   = w_key_full;
          w_key_loaded_nxt = 1'b1;
          w_state_nxt      = S_READY;
        end else if (w_error) begin
          if (r_fail_cnt != FW'(MAX_FAIL)) w_fail_nxt = r_fail_cnt + FW'(1);
          if (w_fail_nxt == FW'(MAX_FAIL)) begin
            w_lockout_nxt  = 1'b1;
            w_core_key_nxt = '0;
            w_core_d_nxt   = '0;
            w_state_nxt    = S_LOCKOUT;
          end else begin
            w_state_nxt = S_NO_KEY;
          end
        end else if (w_beat) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_READY: begin
        if (key_clear) begin
          w_core_key_nxt   = '0;
          w_key_loaded_nxt = 1'b0;
          w_state_nxt      = S_NO_KEY;
        end else if (req_valid) begin
          w_core_d_nxt = req_data;
          w_state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        w_strobe_nxt = '0;
        w_state_nxt  = S_STROBE;
      end
      S_STROBE: begin
        if (r_strobe_cnt == SW'(STROBE_CYC - 1)) w_state_nxt = S_HOLD;
        else w_strobe_nxt = r_strobe_cnt + SW'(1);
      end
      S_HOLD: begin
        w_resp_data_nxt = core_q;
        w_state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (r_resp_valid && resp_ready) w_state_nxt = S_READY;
      end
      S_LOCKOUT: begin
        w_core_key_nxt   = '0;
        w_core_d_nxt     = '0;
        w_key_loaded_nxt = 1'b0;
      end
      default: w_state_nxt = S_NO_KEY;
    endcase
  end

  assign core_en    = r_core_en;
  assign resp_valid = r_resp_valid;
  assign core_d     = r_core_d;
  assign resp_data  = r_resp_data;
  assign core_key   = r_core_key;
  assign key_loaded = r_key_loaded;
  assign lockout    = r_lockout;
  assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_lock_key_sequencer.sv
// Self-checking bench for lock_key_sequencer (default parameters).
module tb_lock_key_sequencer;

  logic        clk, rst_n;
  logic        key_valid, key_ready, key_last, key_clear;
  logic [7:0]  key_data;
  logic        req_valid, req_ready;
  logic [3:0]  req_data;
  logic        resp_valid, resp_ready;
  logic [3:0]  resp_data, core_d, core_q;
  logic        core_en, key_loaded, lockout;
  logic [31:0] core_key;
  logic [1:0]  fail_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  lock_key_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .key_last(key_last), .key_clear(key_clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .core_d(core_d), .core_en(core_en), .core_key(core_key), .core_q(core_q),
    .key_loaded(key_loaded), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  // Transparent core model: q follows d
  assign core_q = core_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [7:0]  kd;
    logic        kl;
    logic        kc;
    logic        rv;
    logic [3:0]  rd;
    logic        e_kr;
    logic        e_rr;
    logic        e_kl;
    logic        e_en;
    logic [31:0] e_key;
    logic [1:0]  e_fail;
    logic        e_lo;
  } vec_t;

  vec_t vec [0:20];

  function automatic vec_t mk(input logic kv, input logic [7:0] kd, input logic kl,
                              input logic kc, input logic rv, input logic [3:0] rd,
                              input logic e_kr, input logic e_rr, input logic e_kl,
                              input logic [31:0] e_key, input logic [1:0] e_fail,
                              input logic e_lo);
    vec_t v;
    v.kv = kv; v.kd = kd; v.kl = kl; v.kc = kc; v.rv = rv; v.rd = rd;
    v.e_kr = e_kr; v.e_rr = e_rr; v.e_kl = e_kl; v.e_en = 1'b0;
    v.e_key = e_key; v.e_fail = e_fail; v.e_lo = e_lo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      key_valid = vec[i].kv; key_data = vec[i].kd; key_last = vec[i].kl;
      key_clear = vec[i].kc; req_valid = vec[i].rv; req_data = vec[i].rd;
      step();
      chk($sformatf("v%0d.key_ready", i),  64'(key_ready),  64'(vec[i].e_kr));
      chk($sformatf("v%0d.req_ready", i),  64'(req_ready),  64'(vec[i].e_rr));
      chk($sformatf("v%0d.key_loaded", i), 64'(key_loaded), 64'(vec[i].e_kl));
      chk($sformatf("v%0d.core_en", i),    64'(core_en),    64'(vec[i].e_en));
      chk($sformatf("v%0d.core_key", i),   64'(core_key),   64'(vec[i].e_key));
      chk($sformatf("v%0d.fail_cnt", i),   64'(fail_cnt),   64'(vec[i].e_fail));
      chk($sformatf("v%0d.lockout", i),    64'(lockout),    64'(vec[i].e_lo));
    end
    key_valid = 1'b0; key_last = 1'b0; key_clear = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    // Malformed (no key_last), good load, clear-vs-request, good load
    vec[0]  = mk(1, 8'hDE, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd0, 0);
    vec[1]  = mk(1, 8'hAD, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd0, 0);
    vec[2]  = mk(1, 8'hBE, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd0, 0);
    vec[3]  = mk(1, 8'hEF, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[4]  = mk(1, 8'h12, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[5]  = mk(1, 8'h34, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[6]  = mk(1, 8'h56, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[7]  = mk(1, 8'h78, 1, 0, 0, 4'h0, 0, 1, 1, 32'h12345678, 2'd1, 0);
    vec[8]  = mk(0, 8'h00, 0, 1, 1, 4'hF, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[9]  = mk(1, 8'hDE, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[10] = mk(1, 8'hAD, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[11] = mk(1, 8'hBE, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[12] = mk(1, 8'hEF, 1, 0, 0, 4'h0, 0, 1, 1, 32'hDEADBEEF, 2'd1, 0);
    // Three early-key_last loads after reset, then ignored inputs in lockout
    vec[13] = mk(1, 8'h11, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd0, 0);
    vec[14] = mk(1, 8'h22, 1, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[15] = mk(1, 8'h33, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd1, 0);
    vec[16] = mk(1, 8'h44, 1, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd2, 0);
    vec[17] = mk(1, 8'h55, 0, 0, 0, 4'h0, 1, 0, 0, 32'h0, 2'd2, 0);
    vec[18] = mk(1, 8'h66, 1, 0, 0, 4'h0, 0, 0, 0, 32'h0, 2'd3, 1);
    vec[19] = mk(1, 8'h77, 1, 0, 0, 4'h0, 0, 0, 0, 32'h0, 2'd3, 1);
    vec[20] = mk(1, 8'h88, 0, 1, 1, 4'h5, 0, 0, 0, 32'h0, 2'd3, 1);

    rst_n = 1'b0; key_valid = 1'b0; key_data = 8'h00; key_last = 1'b0;
    key_clear = 1'b0; req_valid = 1'b0; req_data = 4'h0; resp_ready = 1'b0;

    // Reset values
    #12;
    chk("rst.core_en",    64'(core_en),    64'(0));
    chk("rst.core_key",   64'(core_key),   64'(0));
    chk("rst.core_d",     64'(core_d),     64'(0));
    chk("rst.resp_valid", 64'(resp_valid), 64'(0));
    chk("rst.resp_data",  64'(resp_data),  64'(0));
    chk("rst.key_loaded", 64'(key_loaded), 64'(0));
    chk("rst.lockout",    64'(lockout),    64'(0));
    chk("rst.fail_cnt",   64'(fail_cnt),   64'(0));
    #6 rst_n = 1'b1;

    run_range(0, 12);

    // Request timing and response back-pressure
    req_valid = 1'b1; req_data = 4'b1010; resp_ready = 1'b0;
    step();
    chk("req.k0.core_d",    64'(core_d),    64'(4'b1010));
    chk("req.k0.core_en",   64'(core_en),   64'(0));
    chk("req.k0.req_ready", 64'(req_ready), 64'(0));
    req_data = 4'b0101;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("req.k%0d.core_en", k),    64'(core_en),    64'(k == 2 || k == 3));
      chk($sformatf("req.k%0d.core_d", k),     64'(core_d),     64'(4'b1010));
      chk($sformatf("req.k%0d.resp_valid", k), 64'(resp_valid), 64'(k >= 5));
      chk($sformatf("req.k%0d.req_ready", k),  64'(req_ready),  64'(0));
      if (k >= 5) chk($sformatf("req.k%0d.resp_data", k), 64'(resp_data), 64'(4'b1010));
    end
    resp_ready = 1'b1;
    step();
    chk("req.hs.resp_valid", 64'(resp_valid), 64'(0));
    chk("req.hs.req_ready",  64'(req_ready),  64'(1));
    chk("req.hs.core_d",     64'(core_d),     64'(4'b1010));
    req_valid = 1'b0; resp_ready = 1'b0;

    // key_clear held through the strobe sequence is ignored
    req_valid = 1'b1; req_data = 4'b0110;
    step();
    req_valid = 1'b0; key_clear = 1'b1; resp_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("clr.k%0d.core_en", k),    64'(core_en),    64'(k == 2 || k == 3));
      chk($sformatf("clr.k%0d.key_loaded", k), 64'(key_loaded), 64'(1));
      if (k == 4) key_clear = 1'b0;
    end
    chk("clr.resp_valid", 64'(resp_valid), 64'(1));
    chk("clr.resp_data",  64'(resp_data),  64'(4'b0110));
    step();
    chk("clr.hs.resp_valid", 64'(resp_valid), 64'(0));
    chk("clr.hs.req_ready",  64'(req_ready),  64'(1));
    chk("clr.hs.core_key",   64'(core_key),   64'(32'hDEADBEEF));
    resp_ready = 1'b0;

    // Asynchronous reset in the second strobe cycle
    req_valid = 1'b1; req_data = 4'b1100;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("ars.k2.core_en", 64'(core_en), 64'(1));
    step();
    chk("ars.k3.core_en", 64'(core_en), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ars.core_en",    64'(core_en),    64'(0));
    chk("ars.core_key",   64'(core_key),   64'(0));
    chk("ars.resp_valid", 64'(resp_valid), 64'(0));
    chk("ars.key_loaded", 64'(key_loaded), 64'(0));
    chk("ars.core_d",     64'(core_d),     64'(0));
    #3 rst_n = 1'b1;
    #1;
    chk("ars.key_ready", 64'(key_ready), 64'(1));
    chk("ars.req_ready", 64'(req_ready), 64'(0));

    run_range(13, 20);

    // Only reset leaves lockout
    step();
    chk("lock.hold.lockout",   64'(lockout),   64'(1));
    chk("lock.hold.key_ready", 64'(key_ready), 64'(0));
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    chk("unlock.lockout",   64'(lockout),   64'(0));
    chk("unlock.fail_cnt",  64'(fail_cnt),  64'(0));
    chk("unlock.key_ready", 64'(key_ready), 64'(1));
    chk("unlock.core_key",  64'(core_key),  64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
